// File: rtl/life_fifo_reader.sv
// Consumer for the life-counted FIFO: issues deq, captures {val, life-1}, and
// presents it on valid/ready. Optional counters under LIFE_FIFO_READER_STATS_EN.
module life_fifo_reader #(
  parameter int VAL_W  = 16,
  parameter int LIFE_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fifo_empty,
  input  logic [VAL_W+LIFE_W-1:0] fifo_dout,
  output logic                    fifo_deq,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [VAL_W-1:0]        out_val,
  output logic [LIFE_W-1:0]       out_life,
  output logic                    out_last,
  output logic                    busy
`ifdef LIFE_FIFO_READER_STATS_EN
  ,
  output logic [15:0]             rd_count,
  output logic [15:0]             retire_count
`endif
);

  typedef enum logic [1:0] {IDLE, PEND, HOLD} state_t;

  state_t state, state_nxt;
  logic   out_valid_nxt;
  logic   handshake;

  assign busy      = (state != IDLE);
  assign handshake = out_valid && out_ready;

  // At most one dequeue in flight: deq only from IDLE or on a HOLD handshake.
  always_comb begin
    state_nxt     = state;
    out_valid_nxt = out_valid;
    fifo_deq      = 1'b0;
    case (state)
      IDLE: begin
        fifo_deq = !fifo_empty;
        if (!fifo_empty) state_nxt = PEND;
      end
      PEND: begin
        out_valid_nxt = 1'b1;
        state_nxt     = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          fifo_deq      = !fifo_empty;
          out_valid_nxt = 1'b0;
          state_nxt     = fifo_empty ? IDLE : PEND;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (rst) fifo_deq = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_val   <= '0;
      out_life  <= '0;
      out_last  <= 1'b0;
    end else begin
      state     <= state_nxt;
      out_valid <= out_valid_nxt;
      if (state == PEND) begin
        out_val  <= fifo_dout[VAL_W+LIFE_W-1:LIFE_W];
        out_life <= fifo_dout[LIFE_W-1:0];
        out_last <= (fifo_dout[LIFE_W-1:0] == '0);
      end
    end
  end

`ifdef LIFE_FIFO_READER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_count     <= '0;
      retire_count <= '0;
    end else if (handshake) begin
      if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
      if (out_last && retire_count != 16'hFFFF) retire_count <= retire_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_life_fifo_reader.sv
// Bench for life_fifo_reader: queue-based FIFO/delivery model plus directed scenarios.
module tb_life_fifo_reader;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fifo_empty = 1'b1;
  logic [31:0] fifo_dout = '0;
  logic        fifo_deq, out_valid, out_last, busy;
  logic        out_ready = 1'b0;
  logic [15:0] out_val, out_life;
`ifdef LIFE_FIFO_READER_STATS_EN
  logic [15:0] rd_count, retire_count;
`endif

  always #5 clk = ~clk;

  life_fifo_reader #(.VAL_W(16), .LIFE_W(16)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
    .fifo_deq(fifo_deq), .out_valid(out_valid), .out_ready(out_ready),
    .out_val(out_val), .out_life(out_life), .out_last(out_last), .busy(busy)
`ifdef LIFE_FIFO_READER_STATS_EN
    , .rd_count(rd_count), .retire_count(retire_count)
`endif
  );

  typedef struct packed {logic [15:0] v; logic [15:0] l;} ent_t;
  typedef struct packed {logic [15:0] v; logic [15:0] l; logic last;} dlv_t;
  typedef struct {int c; dlv_t d;} hs_t;

  ent_t fq[$];
  ent_t push_q[$];
  dlv_t exp_q[$];
  hs_t  hs_log[$];
  int   deq_cyc[$];
  logic clr_req = 1'b0;
  logic deq_s = 1'b0;
  int   n_chk = 0, n_fail = 0;
  int   cyc = 0, deq_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  // FIFO model: deq sampled at the edge returns {val, life-1} next cycle; retires at 0.
  ent_t fh, fp;
  dlv_t fd;
  always @(posedge clk) begin
    if (clr_req) begin
      fq.delete();
      exp_q.delete();
    end else if (deq_s && fq.size() > 0) begin
      fh = fq[0];
      fh.l = fh.l - 16'd1;
      fifo_dout <= {fh.v, fh.l};
      if (fh.l == 16'd0) void'(fq.pop_front());
      else fq[0] = fh;
    end
    while (push_q.size() > 0) begin
      fp = push_q.pop_front();
      fq.push_back(fp);
      for (int i = int'(fp.l) - 1; i >= 0; i--) begin
        fd.v = fp.v;
        fd.l = i[15:0];
        fd.last = (i == 0);
        exp_q.push_back(fd);
      end
    end
    fifo_empty <= (fq.size() == 0);
  end

  // Per-cycle compare against the delivery model and protocol rules.
  logic        pv = 1'b0, phs = 1'b0, d1 = 1'b0, d2 = 1'b0;
  logic [15:0] pval = '0, plife = '0;
  logic        plast = 1'b0;
  dlv_t        ce;
  hs_t         hl;
  always @(negedge clk) begin
    cyc++;
    deq_s = fifo_deq;
    if (rst) begin
      check("deq_in_rst", fifo_deq, 0);
      pv = 0; phs = 0; d1 = 0; d2 = 0;
    end else begin
      if (fifo_deq) begin
        deq_cnt++;
        deq_cyc.push_back(cyc);
      end
      if (fifo_empty) check("deq_when_empty", fifo_deq, 0);
      if (out_valid) check("busy_when_valid", busy, 1);
      if (out_valid && !pv) check("deq_to_valid_2", d2, 1);
      if (out_valid && pv && !phs) begin
        check("hold_val", out_val, pval);
        check("hold_life", out_life, plife);
        check("hold_last", out_last, plast);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) fail("unexpected_delivery");
        else begin
          ce = exp_q.pop_front();
          check("dlv_val", out_val, ce.v);
          check("dlv_life", out_life, ce.l);
          check("dlv_last", out_last, ce.last);
        end
        hl.c = cyc;
        hl.d = {out_val, out_life, out_last};
        hs_log.push_back(hl);
      end
      d2 = d1; d1 = fifo_deq;
      pv = out_valid; phs = out_valid && out_ready;
      pval = out_val; plife = out_life; plast = out_last;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] v, input logic [15:0] l);
    ent_t e;
    e.v = v;
    e.l = l;
    push_q.push_back(e);
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (!(exp_q.size() == 0 && fq.size() == 0 && push_q.size() == 0 && !busy) && k < 100) begin
      tick;
      k++;
    end
    if (k >= 100) fail(name);
  endtask

  task automatic wait_hs(input int n, input string name);
    int k = 0;
    while (hs_log.size() < n && k < 100) begin
      tick;
      k++;
    end
    if (k >= 100) fail(name);
  endtask

  task automatic check_dlv(input string name, input int idx, input logic [15:0] v,
                           input logic [15:0] l, input logic last);
    if (idx >= hs_log.size()) fail(name);
    else begin
      check({name, "_val"}, hs_log[idx].d.v, v);
      check({name, "_life"}, hs_log[idx].d.l, l);
      check({name, "_last"}, hs_log[idx].d.last, last);
    end
  endtask

  initial begin
    int d0, h0, k;
    // 1: reset with a non-empty FIFO
    out_ready = 1'b1;
    push(16'd5, 16'd1);
    tick; tick; tick;
    check("t1_fifo_nonempty_in_rst", fifo_empty, 0);
    check("t1_deq_in_rst", fifo_deq, 0);
    rst = 1'b0;
    @(negedge clk);
    check("t1_valid", out_valid, 0);
    check("t1_val", out_val, 0);
    check("t1_life", out_life, 0);
    check("t1_last", out_last, 0);
    check("t1_busy", busy, 0);
    wait_idle("t1_drain_timeout");

    // 2: single entry {149,1}
    d0 = deq_cnt; h0 = hs_log.size();
    push(16'd149, 16'd1);
    wait_hs(h0 + 1, "t2_timeout");
    check_dlv("t2", h0, 16'd149, 16'd0, 1'b1);
    if (hs_log.size() > h0 && deq_cyc.size() > d0)
      check("t2_latency", hs_log[h0].c - deq_cyc[d0], 2);
    repeat (4) tick;
    check("t2_deq_once", deq_cnt - d0, 1);
    check("t2_idle", busy, 0);

    // 3: {42,3} then {27,1}, back-to-back
    rst = 1'b1; tick; rst = 1'b0;
    d0 = deq_cnt; h0 = hs_log.size();
    push(16'd42, 16'd3);
    push(16'd27, 16'd1);
    wait_hs(h0 + 4, "t3_timeout");
    check_dlv("t3_d0", h0,     16'd42, 16'd2, 1'b0);
    check_dlv("t3_d1", h0 + 1, 16'd42, 16'd1, 1'b0);
    check_dlv("t3_d2", h0 + 2, 16'd42, 16'd0, 1'b1);
    check_dlv("t3_d3", h0 + 3, 16'd27, 16'd0, 1'b1);
    if (hs_log.size() >= h0 + 4)
      for (int i = 1; i < 4; i++)
        check("t3_spacing", hs_log[h0 + i].c - hs_log[h0 + i - 1].c, 2);
    wait_idle("t3_drain_timeout");
    check("t3_deq_count", deq_cnt - d0, 4);
`ifdef LIFE_FIFO_READER_STATS_EN
    check("t6_rd_count", rd_count, 4);
    check("t6_retire_count", retire_count, 2);
`endif

    // 4: backpressure on {3,4}
    out_ready = 1'b0;
    h0 = hs_log.size();
    push(16'd3, 16'd4);
    k = 0;
    while (!out_valid && k < 20) begin tick; k++; end
    if (k >= 20) fail("t4_valid_timeout");
    repeat (5) begin
      @(negedge clk);
      check("t4_valid", out_valid, 1);
      check("t4_val", out_val, 3);
      check("t4_life", out_life, 3);
      check("t4_no_deq", fifo_deq, 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("t4_hs_valid", out_valid, 1);
    check("t4_hs_deq", fifo_deq, 1);
    wait_hs(h0 + 2, "t4_timeout");
    check_dlv("t4_first", h0, 16'd3, 16'd3, 1'b0);
    check_dlv("t4_next", h0 + 1, 16'd3, 16'd2, 1'b0);
    wait_idle("t4_drain_timeout");

    // 5: reset while in PEND for {667,1}
    push(16'd667, 16'd1);
    k = 0;
    while (!fifo_deq && k < 20) begin tick; k++; end
    if (k >= 20) fail("t5_deq_timeout");
    @(posedge clk); #1;
    check("t5_pend_busy", busy, 1);
    rst = 1'b1; clr_req = 1'b1;
    tick;
    clr_req = 1'b0;
    check("t5_idle_after_rst", busy, 0);
    check("t5_valid_after_rst", out_valid, 0);
    rst = 1'b0;
    h0 = hs_log.size();
    repeat (6) begin
      tick;
      check("t5_valid_stays_low", out_valid, 0);
    end
    check("t5_no_delivery", hs_log.size() - h0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/life_fifo_reader.md
Name: life_fifo_reader

Overview:
Consumer-side controller for the life-counted FIFO, whose entries are {val, life}. Each dequeue of that FIFO returns the head entry with its life decremented. The FIFO retires the entry once the returned life is 0. This block issues the FIFO's deq strobe, captures the returned entry, and presents it downstream on a valid/ready handshake, flagging the final (retiring) delivery of each entry.

Parameters:
VAL_W, 16, width of value field
LIFE_W, 16, width of life field

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
fifo_empty  input  1  FIFO empty flag
fifo_dout  input  VAL_W+LIFE_W  FIFO output {val, life}; valid the cycle after deq is sampled
fifo_deq  output  1  dequeue strobe to FIFO
out_valid  output  1  downstream data valid
out_ready  input  1  downstream accept
out_val  output  VAL_W  captured val
out_life  output  LIFE_W  captured (post-decrement) life
out_last  output  1  captured life == 0, entry retired by FIFO
busy  output  1  state != IDLE

Behaviour:
- Reset (rst=1 at posedge): state=IDLE; out_valid=0, out_val=0, out_life=0, out_last=0. fifo_deq=0 combinationally while rst=1.
- FIFO contract: deq sampled at edge N; fifo_dout carries the dequeued {val, life-1} during cycle N+1.
- States: IDLE, PEND, HOLD.
- IDLE:
  - fifo_deq = !fifo_empty.
  - If fifo_deq, next state is PEND; else stay in IDLE.
- PEND:
  - fifo_deq=0; fifo_empty is ignored.
  - At the edge: out_val<=fifo_dout[VAL_W+LIFE_W-1:LIFE_W], out_life<=fifo_dout[LIFE_W-1:0], out_last<=(fifo_dout[LIFE_W-1:0]==0), out_valid<=1. Next state is HOLD.
- HOLD:
  - out_valid=1. out_val, out_life and out_last are held stable until the handshake.
  - If out_ready && !fifo_empty: fifo_deq=1 in the same cycle, out_valid<=0, next state is PEND (back-to-back issue).
  - If out_ready && fifo_empty: out_valid<=0, next state is IDLE.
  - If !out_ready: fifo_deq=0, stay in HOLD.
- Latency: deq strobe to out_valid = 2 cycles. Peak throughput is 1 delivery per 2 cycles with out_ready tied high.
- fifo_deq is never asserted while fifo_empty=1. At most one dequeue is outstanding (no deq in PEND).
- out_val, out_life and out_last change only at the PEND->HOLD edge.
- out_ready while out_valid=0 is ignored.
- Reset mid-PEND or mid-HOLD: the captured or in-flight entry is discarded; the FIFO is reset by the same rst.
- fifo_empty falling during PEND or HOLD (without handshake) takes no action until HOLD is exited or IDLE is re-entered.
- busy is combinational from state.

Optional Feature:
LIFE_FIFO_READER_STATS_EN
- Defined: adds output ports rd_count (16) and retire_count (16).
  - rd_count increments on every out_valid&&out_ready.
  - retire_count increments on handshakes with out_last=1.
  - Both saturate at 16'hFFFF and clear on rst.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
1. rst=1 for 2 cycles with fifo_empty=0 -> fifo_deq=0 throughout; out_valid=0, out_val=0, out_life=0, out_last=0 after release.
2. FIFO model holds {149,1}, out_ready=1:
   - deq at cycle 0; out_valid=1 at cycle 2 with out_val=149, out_life=0, out_last=1.
   - fifo_empty=1 afterwards -> state returns to IDLE, fifo_deq stays 0.
3. FIFO holds {42,3} then {27,1}, out_ready=1:
   - deliveries are (42,2,0), (42,1,0), (42,0,1), (27,0,1), one every 2 cycles.
   - fifo_deq pulses exactly 4 times.
4. Backpressure, FIFO holds {3,4}, out_ready=0 for 5 cycles after out_valid:
   - out_val=3 and out_life=3 are held stable; fifo_deq=0 for all 5 cycles.
   - Raising out_ready gives one handshake, then the next deq the same cycle; the next delivery is (3,2).
5. rst asserted while in PEND for {667,1} -> out_valid stays 0, state is IDLE on the next cycle, and no delivery of 667 appears.
6. With LIFE_FIFO_READER_STATS_EN defined, after scenario 3 -> rd_count=4, retire_count=2. Preload rd_count to 16'hFFFF, then 1 more handshake -> stays 16'hFFFF.
